// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding, command payload and dot-address helper for
// the 160x120 framebuffer blocks.
package vga_pkg;

  localparam int unsigned H_DOTS     = 160;
  localparam int unsigned V_DOTS     = 120;
  localparam int unsigned COLOR_BITS = 3;
  localparam int unsigned FB_AW      = 15;
  localparam int unsigned FB_DEPTH   = H_DOTS * V_DOTS;
  localparam int unsigned XW         = 8;
  localparam int unsigned YW         = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // Latched rectangle-fill command.
  typedef struct packed {
    logic [XW-1:0]         x0;
    logic [YW-1:0]         y0;
    logic [XW-1:0]         w;
    logic [YW-1:0]         h;
    logic [COLOR_BITS-1:0] color;
  } fill_cmd_t;

  // Linear dot address y*160+x, built from shifts so no multiplier is needed.
  function automatic logic [FB_AW-1:0] dot_addr(input logic [XW-1:0] dx,
                                                input logic [YW-1:0] dy);
    return FB_AW'({dy, 7'b0}) + FB_AW'({dy, 5'b0}) + FB_AW'(dx);
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old data.
module vga_fb_ram
  import vga_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [FB_AW-1:0]      waddr,
  input  logic [COLOR_BITS-1:0] wdata,
  input  logic [FB_AW-1:0]      raddr,
  output logic [COLOR_BITS-1:0] rdata
);

  logic [COLOR_BITS-1:0] mem [FB_DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; sees the pre-write contents on collision.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill pixel source: accepts fill commands, clips them to the
// 160x120 screen, writes one dot per clock, and returns the stored colour at
// the scan position requested by the display controller.
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [XW-1:0]         cmd_w,
  input  logic [YW-1:0]         cmd_h,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic                  busy,
  output logic                  done,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  output logic [COLOR_BITS-1:0] color
);

  fill_state_e           state_q, state_d;
  fill_cmd_t             cmd_q, cmd_d;
  logic [XW-1:0]         xe_q, xe_d;
  logic [YW-1:0]         ye_q, ye_d;
  logic [XW-1:0]         cx_q, cx_d;
  logic [YW-1:0]         cy_q, cy_d;
  logic                  cmd_ready_d, busy_d, done_d;

  logic [XW:0]           x_sum_c;
  logic [YW:0]           y_sum_c;
  logic                  null_c;
  logic                  fb_we_c;
  logic [FB_AW-1:0]      fb_waddr_c;
  logic                  rd_in_range_c;
  logic [FB_AW-1:0]      fb_raddr_c;
  logic                  rd_in_range_q;
  logic [COLOR_BITS-1:0] fb_rdata;

  // Clip arithmetic with one extra bit so x0+w / y0+h never wrap.
  always_comb begin
    x_sum_c = {1'b0, cmd_q.x0} + {1'b0, cmd_q.w};
    y_sum_c = {1'b0, cmd_q.y0} + {1'b0, cmd_q.h};
    null_c  = (cmd_q.w == '0) || (cmd_q.h == '0) ||
              (cmd_q.x0 >= XW'(H_DOTS)) || (cmd_q.y0 >= YW'(V_DOTS));
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state, datapath updates and registered-output next values.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    fb_we_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d   = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
          state_d = CLIP;
        end
      end
      CLIP: begin
        xe_d = (x_sum_c > (XW+1)'(H_DOTS)) ? XW'(H_DOTS) : x_sum_c[XW-1:0];
        ye_d = (y_sum_c > (YW+1)'(V_DOTS)) ? YW'(V_DOTS) : y_sum_c[YW-1:0];
        cx_d = cmd_q.x0;
        cy_d = cmd_q.y0;
        state_d = null_c ? DONE : FILL;
      end
      FILL: begin
        fb_we_c = 1'b1;
        if (cx_q + XW'(1) == xe_q) begin
          cx_d = cmd_q.x0;
          if (cy_q + YW'(1) == ye_q) begin
            state_d = DONE;
          end else begin
            cy_d = cy_q + YW'(1);
          end
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d == CLIP) || (state_d == FILL);
    done_d      = (state_d == DONE);
  end

  // Write and read addresses; out-of-screen scans read a safe address.
  always_comb begin
    fb_waddr_c    = dot_addr(cx_q, cy_q);
    rd_in_range_c = (x < XW'(H_DOTS)) && (y < YW'(V_DOTS));
    fb_raddr_c    = rd_in_range_c ? dot_addr(x, y) : '0;
  end

  // Range flag travels alongside the RAM read so off-screen dots come out black.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_in_range_q <= 1'b0;
    end else begin
      rd_in_range_q <= rd_in_range_c;
    end
  end

  vga_fb_ram u_fb_ram (
    .clk   (CLOCK_50),
    .we    (fb_we_c),
    .waddr (fb_waddr_c),
    .wdata (cmd_q.color),
    .raddr (fb_raddr_c),
    .rdata (fb_rdata)
  );

  assign color = rd_in_range_q ? fb_rdata : '0;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: a dot-array model of the screen plus
// command timing derived from the clipped rectangle area.
module tb_vga_rect_fill;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x0 = '0;
  logic [6:0] cmd_y0 = '0;
  logic [7:0] cmd_w = '0;
  logic [6:0] cmd_h = '0;
  logic [2:0] cmd_color = '0;
  logic       busy, done;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] color;

  int total = 0;
  int bad = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  vga_rect_fill dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .color     (color)
  );

  // Screen model and the one command in flight.
  logic [2:0] fb_m [19200];
  bit         known [19200];
  int         edge_n = 0;
  bit         cmd_live = 0;
  int         e_acc, a_area, c_x0, c_y0, c_wc;
  logic [2:0] c_col;
  bit         rand_scan = 1;

  task automatic chk(input string nm, input int got, input int exp_v);
    total++;
    if (got != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp_v, edge_n);
    end
  endtask

  // Clipped area of a command; 0 for null commands.
  function automatic int model_area(input int x0, input int y0, input int w, input int h,
                                    output int wc);
    int xe, ye;
    wc = 1;
    if (w == 0 || h == 0 || x0 >= 160 || y0 >= 120) return 0;
    xe = (x0 + w > 160) ? 160 : x0 + w;
    ye = (y0 + h > 120) ? 120 : y0 + h;
    wc = xe - x0;
    return wc * (ye - y0);
  endfunction

  // Advance one clock and check every output against the model.
  task automatic tick();
    int px, py, i, ec, ebusy, edone, erdy, wc;
    bit prst, acc, cchk;
    px = int'(x); py = int'(y); prst = reset;
    acc = cmd_valid && cmd_ready && !reset;
    if (acc) begin
      c_x0 = int'(cmd_x0); c_y0 = int'(cmd_y0); c_col = cmd_color;
      a_area = model_area(c_x0, c_y0, int'(cmd_w), int'(cmd_h), wc);
      c_wc = wc;
      e_acc = edge_n + 1;
      cmd_live = 1;
    end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    edge_n++;
    cchk = 1;
    ebusy = 0; edone = 0; erdy = 0; ec = 0;
    if (!prst) begin
      if (px < 160 && py < 120) begin
        ec = int'(fb_m[py*160 + px]);
        cchk = known[py*160 + px];
      end
      erdy = 1;
      if (cmd_live) begin
        i = edge_n - e_acc - 2;
        if (i >= 0 && i < a_area) begin
          fb_m[(c_y0 + i / c_wc) * 160 + c_x0 + i % c_wc] = c_col;
          known[(c_y0 + i / c_wc) * 160 + c_x0 + i % c_wc] = 1;
        end
        ebusy = (edge_n <= e_acc + a_area) ? 1 : 0;
        edone = (edge_n == e_acc + a_area + 1) ? 1 : 0;
        erdy  = 0;
        if (edge_n == e_acc + a_area + 1) cmd_live = 0;
      end
    end
    if (cchk) chk("color", int'(color), ec);
    chk("busy", int'(busy), ebusy);
    chk("cmd_ready", int'(cmd_ready), erdy);
    chk("done", int'(done), edone);
    if (rand_scan) begin
      x = 8'($urandom_range(199, 0));
      y = 7'($urandom_range(127, 0));
    end
  endtask

  task automatic start_cmd(input string nm, input int x0, input int y0, input int w,
                           input int h, input int c);
    bit got = 0;
    cmd_x0 = 8'(x0); cmd_y0 = 7'(y0); cmd_w = 8'(w); cmd_h = 7'(h); cmd_color = 3'(c);
    cmd_valid = 1'b1;
    for (int t = 0; t < 40000 && !got; t++) begin
      got = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!got) chk({nm, "_accept"}, 0, 1);
  endtask

  // Cycles are counted from the accept edge: the first cycle after it is 1.
  task automatic wait_done(input string nm, input int exp_lat);
    int k = 1;
    bit got = 0;
    while (!got && k < 25000) begin
      if (done) got = 1;
      else begin tick(); k++; end
    end
    chk({nm, "_latency"}, got ? k : -1, exp_lat);
  endtask

  task automatic issue(input string nm, input int x0, input int y0, input int w,
                       input int h, input int c, input int exp_lat);
    start_cmd(nm, x0, y0, w, h, c);
    wait_done(nm, exp_lat);
  endtask

  task automatic rd(input string nm, input int xx, input int yy, input int lit);
    x = 8'(xx); y = 7'(yy);
    tick();
    chk(nm, int'(color), lit);
  endtask

  task automatic hit_reset(input int cycles);
    reset = 1'b1; cmd_valid = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_color", int'(color), 0);
    cmd_live = 0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    int k, dk, wc, x0, y0, w, h;
    bit accb;

    repeat (3) tick();
    chk("reset_ready", int'(cmd_ready), 0);
    chk("reset_color", int'(color), 0);
    reset = 1'b0;

    // Establish a known all-black screen.
    issue("init_fill", 0, 0, 160, 120, 0, 19202);

    issue("small", 10, 5, 3, 2, 4, 8);
    rd("small_10_5", 10, 5, 4);
    rd("small_12_6", 12, 6, 4);
    rd("small_11_5", 11, 5, 4);
    rd("small_13_5", 13, 5, 0);
    rd("small_10_7", 10, 7, 0);

    issue("clip", 158, 118, 10, 10, 2, 6);
    rd("clip_158_118", 158, 118, 2);
    rd("clip_159_119", 159, 119, 2);
    rd("clip_0_118", 0, 118, 0);
    rd("clip_158_0", 158, 0, 0);
    rd("clip_157_118", 157, 118, 0);

    issue("null_w0", 0, 0, 0, 5, 7, 2);
    issue("null_x160", 160, 0, 5, 5, 7, 2);
    rd("null_0_0", 0, 0, 0);
    rd("null_159_119", 159, 119, 2);

    // Back-to-back with cmd_valid held: second accepted right after DONE.
    start_cmd("b2b_a", 20, 20, 4, 4, 1);
    cmd_x0 = 8'd22; cmd_y0 = 7'd22; cmd_w = 8'd4; cmd_h = 7'd4; cmd_color = 3'd6;
    cmd_valid = 1'b1;
    k = 1; dk = -1; accb = 0;
    while (!accb && k < 100) begin
      if (done) dk = k;
      accb = cmd_ready;
      tick();
      k++;
    end
    cmd_valid = 1'b0;
    chk("b2b_a_done", dk, 18);
    chk("b2b_b_accept", k, 20);
    wait_done("b2b_b", 18);
    rd("b2b_21_21", 21, 21, 1);
    rd("b2b_22_22", 22, 22, 6);
    rd("b2b_25_25", 25, 25, 6);
    rd("b2b_23_21", 23, 21, 1);
    rd("b2b_23_23", 23, 23, 6);

    rd("bound_160_0", 160, 0, 0);
    rd("bound_0_120", 0, 120, 0);
    rd("bound_199_127", 199, 127, 0);

    // Randomized commands, including off-screen and zero-size ones.
    for (int n = 0; n < 12; n++) begin
      x0 = int'($urandom_range(170, 0));
      y0 = int'($urandom_range(127, 0));
      w  = int'($urandom_range(40, 0));
      h  = int'($urandom_range(30, 0));
      issue("rand", x0, y0, w, h, int'($urandom_range(7, 0)),
            model_area(x0, y0, w, h, wc) + 2);
      repeat (20) tick();
    end

    issue("full_white", 0, 0, 160, 120, 7, 19202);
    rd("full_0_0", 0, 0, 7);
    rd("full_159_119", 159, 119, 7);

    // Reset after 500 dots of a full-screen fill.
    start_cmd("abort", 0, 0, 160, 120, 5);
    repeat (501) tick();
    hit_reset(3);
    issue("post_reset", 1, 1, 2, 2, 3, 6);
    rd("abort_dot0", 0, 0, 5);
    rd("abort_dot499", 19, 3, 5);
    rd("abort_dot500", 20, 3, 7);
    rd("post_1_1", 1, 1, 3);
    rd("post_2_2", 2, 2, 3);

    repeat (50) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
